// File: rtl/ram_io_responder.sv
// Target side of the CPU byte port: 2^ADDR_WIDTH-byte RAM plus an IO window (UART TX/RX queues, cycle counter, stop strobe).
// Every access returns data exactly one cycle later; no stalls. TX drains on tx_valid&tx_ready, RX fills on rx_valid&rx_ready.
module ram_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TXQ_DEPTH   = 16,
  parameter int RXQ_DEPTH   = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_end
);

  localparam int TXW = $clog2(TXQ_DEPTH);
  localparam int RXW = $clog2(RXQ_DEPTH);
  localparam logic [TXW:0] TX_DEPTH_C = (TXW+1)'(TXQ_DEPTH);
  localparam logic [TXW:0] TX_FULL_AT = (TXW+1)'(TXQ_DEPTH - FULL_MARGIN);
  localparam logic [RXW:0] RX_DEPTH_C = (RXW+1)'(RXQ_DEPTH);

  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} src_e;

  logic                  io;
  logic [2:0]            sel;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_hi;

  assign io        = (mem_a[17:16] == 2'b11);
  assign sel       = mem_a[2:0];
  assign ram_addr  = mem_a[ADDR_WIDTH-1:0];
  assign unused_hi = ^mem_a[31:18];

  // RAM: no reset so it maps onto block RAM and survives a reset
  logic [7:0] ram [0:(2**ADDR_WIDTH)-1];
  logic [7:0] ram_q;

  always_ff @(posedge clk) begin
    if (rst && mem_wr && !io) ram[ram_addr] <= mem_dout;
    ram_q <= ram[ram_addr];
  end

  // TX queue
  logic [7:0]     tx_mem [0:TXQ_DEPTH-1];
  logic [TXW-1:0] tx_head, tx_tail;
  logic [TXW:0]   tx_cnt, tx_cnt_nxt;
  logic           tx_pop, tx_push;

  assign tx_valid = (tx_cnt != '0);
  assign tx_data  = tx_mem[tx_head];
  assign tx_pop   = tx_valid && tx_ready;
  // a full queue still accepts when the same edge pops a byte
  assign tx_push  = io && mem_wr && (sel == 3'd0) && (mem_dout != 8'h00)
                    && ((tx_cnt != TX_DEPTH_C) || tx_pop);

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_push && !tx_pop)      tx_cnt_nxt = tx_cnt + 1'b1;
    else if (!tx_push && tx_pop) tx_cnt_nxt = tx_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_tail] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_head        <= '0;
      tx_tail        <= '0;
      tx_cnt         <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (tx_push) tx_tail <= tx_tail + 1'b1;
      if (tx_pop)  tx_head <= tx_head + 1'b1;
      tx_cnt         <= tx_cnt_nxt;
      io_buffer_full <= (tx_cnt_nxt >= TX_FULL_AT);
    end
  end

  // RX queue
  logic [7:0]     rx_mem [0:RXQ_DEPTH-1];
  logic [RXW-1:0] rx_head, rx_tail;
  logic [RXW:0]   rx_cnt, rx_cnt_nxt;
  logic           rx_pop, rx_push;

  assign rx_ready = (rx_cnt != RX_DEPTH_C);
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = io && !mem_wr && (sel == 3'd0) && (rx_cnt != '0);

  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (rx_push && !rx_pop)      rx_cnt_nxt = rx_cnt + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_nxt = rx_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_tail] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_head <= '0;
      rx_tail <= '0;
      rx_cnt  <= '0;
    end else begin
      if (rx_push) rx_tail <= rx_tail + 1'b1;
      if (rx_pop)  rx_head <= rx_head + 1'b1;
      rx_cnt <= rx_cnt_nxt;
    end
  end

  // IO read mux and read-return path
  logic [31:0] cyc, snap;
  logic [7:0]  io_rd, io_q;
  src_e        src_q;

  always_comb begin
    io_rd = 8'h00;
    case (sel)
      3'd0:    io_rd = (rx_cnt != '0) ? rx_mem[rx_head] : 8'h00;
      3'd4:    io_rd = cyc[7:0];
      3'd5:    io_rd = snap[15:8];
      3'd6:    io_rd = snap[23:16];
      3'd7:    io_rd = snap[31:24];
      default: io_rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q   <= SRC_ZERO;
      io_q    <= 8'h00;
      cyc     <= 32'd0;
      snap    <= 32'd0;
      sim_end <= 1'b0;
    end else begin
      cyc     <= cyc + 32'd1;
      sim_end <= io && mem_wr && (sel == 3'd4);
      // snapshot on the low-byte read so bytes 1..3 stay coherent
      if (io && !mem_wr && (sel == 3'd4)) snap <= cyc;
      if (mem_wr)  src_q <= SRC_ZERO;
      else if (io) src_q <= SRC_IO;
      else         src_q <= SRC_RAM;
      io_q <= (io && !mem_wr) ? io_rd : 8'h00;
    end
  end

  always_comb begin
    mem_din = 8'h00;
    case (src_q)
      SRC_RAM: mem_din = ram_q;
      SRC_IO:  mem_din = io_q;
      default: mem_din = 8'h00;
    endcase
  end

endmodule
